sample_pattern_gen: RTL

Hardware stimulus transmitter for the fir sample interface. It drives the valid_in/data_in side of fir with a Q1.15 square-wave pattern, so the on-chip loopback self-test needs no software. One start pulse emits a fixed-length burst of samples with programmable spacing, then a one-cycle done pulse.

---
 rtl/fir_pkg.sv | 17 +
 rtl/sample_pattern_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fir_pkg.sv
// Types and constants shared between the fir datapath and its
// on-chip stimulus source.
package fir_pkg;

    typedef logic signed [15:0] sample_t;

    localparam sample_t Q15_POS_ONE = 16'h7FFF;
    localparam sample_t Q15_NEG_ONE = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } gen_state_e;

endpackage

// File: rtl/sample_pattern_gen.sv
// Square-wave burst generator feeding the fir sample interface for loopback self-test.
// One start pulse emits N spaced samples, then a one-cycle done pulse.
module sample_pattern_gen
    import fir_pkg::*;
#(
    parameter int                 DATA_W      = 16,
    parameter int                 HALF_PERIOD = 4,
    parameter int                 NUM_PERIODS = 4,
    parameter int                 GAP_CYCLES  = 1,
    parameter logic [DATA_W-1:0]  HIGH_VAL    = DATA_W'(Q15_POS_ONE),
    parameter logic [DATA_W-1:0]  LOW_VAL     = DATA_W'(Q15_NEG_ONE),
    localparam int                N           = 2 * HALF_PERIOD * NUM_PERIODS,
    localparam int                IDX_W       = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     valid_out,
    output logic signed [DATA_W-1:0] data_out,
    output logic [IDX_W-1:0]         sample_idx
);

    localparam int HP_W  = ($clog2(HALF_PERIOD) > 0) ? $clog2(HALF_PERIOD) : 1;
    localparam int GAP_W = ($clog2(GAP_CYCLES) > 0) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HALF_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (HALF_PERIOD < 1) begin : g_bad_half
        $error("sample_pattern_gen: HALF_PERIOD must be >= 1");
    end
    if (NUM_PERIODS < 1) begin : g_bad_periods
        $error("sample_pattern_gen: NUM_PERIODS must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
        $error("sample_pattern_gen: GAP_CYCLES must be >= 0");
    end

    gen_state_e              state, state_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic [HP_W-1:0]         half_cnt, half_nxt, half_step;
    logic                    phase, phase_nxt, phase_step;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic                    valid_nxt, busy_nxt, done_nxt;
    logic signed [DATA_W-1:0] data_nxt;

    // phase flips every HALF_PERIOD samples; it selects low vs high level
    always_comb begin
        half_step  = (half_cnt == HP_LAST) ? '0 : half_cnt + 1'b1;
        phase_step = phase ^ (half_cnt == HP_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_idx <= '0;
            half_cnt   <= '0;
            phase      <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            sample_idx <= idx_nxt;
            half_cnt   <= half_nxt;
            phase      <= phase_nxt;
            gap_cnt    <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = sample_idx;
        half_nxt  = half_cnt;
        phase_nxt = phase;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                    half_nxt  = '0;
                    phase_nxt = 1'b0;
                end
            end
            SEND: begin
                if (sample_idx == IDX_LAST) begin
                    state_nxt = DONE;
                end else if (GAP_CYCLES == 0) begin
                    idx_nxt   = sample_idx + 1'b1;
                    half_nxt  = half_step;
                    phase_nxt = phase_step;
                end else begin
                    state_nxt = GAP;
                    gap_nxt   = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = SEND;
                    idx_nxt   = sample_idx + 1'b1;
                    half_nxt  = half_step;
                    phase_nxt = phase_step;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort overrides everything, including a same-cycle start
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end
    end

    // Outputs are registered images of the state being entered
    always_comb begin
        valid_nxt = (state_nxt == SEND);
        busy_nxt  = (state_nxt == SEND) || (state_nxt == GAP);
        done_nxt  = (state_nxt == DONE);
        data_nxt  = '0;
        if (state_nxt == SEND) begin
            data_nxt = phase_nxt ? LOW_VAL : HIGH_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            data_out  <= data_nxt;
        end
    end

endmodule
